// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, resolves taken branches with a
// one-cycle flush bubble, stops on halt and keeps saturating run counters.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PC_W-1:0]  i_start_addr,
  input  logic             i_stall,
  input  logic             i_branch,
  input  logic [PC_W-1:0]  i_branch_addr,
  input  logic             i_halt,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_instr_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [7:0]       o_taken_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [PC_W-1:0]   r_pc;
  logic              r_busy, r_done;
  logic [CNT_W-1:0]  r_cycles;
  logic [7:0]        r_taken;
  logic              w_exec, w_launch, w_take, w_seq;

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_take   = 1'b0;
    w_seq    = 1'b0;
    w_exec   = (r_state == S_RUN) && !i_stall;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_next   = S_RUN;
          w_launch = 1'b1;
        end
      end
      S_RUN: begin
        // halt wins over branch when both arrive on an executing instruction
        if (w_exec) begin
          if (i_halt) begin
            w_next = S_DONE;
          end else if (i_branch) begin
            w_next = S_FLUSH;
            w_take = 1'b1;
          end else begin
            w_seq = 1'b1;
          end
        end
      end
      S_FLUSH: w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cycles <= '0;
      r_taken  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN) || (w_next == S_FLUSH);
      r_done  <= (w_next == S_DONE);

      if (w_launch)    r_pc <= i_start_addr;
      else if (w_take) r_pc <= i_branch_addr;
      else if (w_seq)  r_pc <= r_pc + PC_W'(1);

      // counters clear on launch and freeze at all-ones
      if (w_launch)
        r_cycles <= '0;
      else if (((r_state == S_RUN) || (r_state == S_FLUSH)) && (r_cycles != '1))
        r_cycles <= r_cycles + CNT_W'(1);

      if (w_launch)
        r_taken <= '0;
      else if (w_take && (r_taken != 8'hFF))
        r_taken <= r_taken + 8'd1;
    end
  end

  assign o_pc          = r_pc;
  assign o_instr_valid = w_exec;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycles;
  assign o_taken_count = r_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes per-cycle expectations from a
// flag-based reference model, monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_pc_sequencer;

  typedef struct {
    int pc;
    bit iv;
    bit busy;
    bit done;
    int cc;
    int tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic       stall = 1'b0;
  logic       branch = 1'b0;
  logic [9:0] branch_addr = '0;
  logic       halt = 1'b0;
  logic [9:0] pc;
  logic       instr_valid, busy, done;
  logic [15:0] cycle_count;
  logic [7:0]  taken_count;

  pc_sequencer #(.PC_W(10), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_start_addr(start_addr),
    .i_stall(stall), .i_branch(branch), .i_branch_addr(branch_addr), .i_halt(halt),
    .o_pc(pc), .o_instr_valid(instr_valid), .o_busy(busy), .o_done(done),
    .o_cycle_count(cycle_count), .o_taken_count(taken_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // reference model: a running program, possibly in its post-branch bubble,
  // or a halted one; counters kept as plain integers
  bit m_active = 0, m_bubble = 0, m_halted = 0;
  int m_pc = 0, m_cc = 0, m_tc = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_bubble = 0; m_halted = 0;
    m_pc = 0; m_cc = 0; m_tc = 0;
  endtask

  // one clock cycle: drive inputs, record what the DUT must show, advance model
  task automatic step(input bit st, input int sa, input bit stl, input bit br,
                      input int ba, input bit hl);
    exp_t e;
    @(negedge clk);
    #1;
    start = st; start_addr = 10'(sa); stall = stl;
    branch = br; branch_addr = 10'(ba); halt = hl;
    e.pc = m_pc; e.busy = m_active; e.done = m_halted;
    e.iv = m_active && !m_bubble && !stl;
    e.cc = m_cc; e.tc = m_tc;
    sb.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (st) begin
        m_active = 1; m_bubble = 0; m_halted = 0;
        m_pc = sa; m_cc = 0; m_tc = 0;
      end
    end else begin
      m_cc = (m_cc + 1 > 65535) ? 65535 : m_cc + 1;
      if (m_bubble) begin
        m_bubble = 0;
      end else if (!stl) begin
        if (hl) begin
          m_active = 0; m_halted = 1;
        end else if (br) begin
          m_pc = ba; m_bubble = 1;
          m_tc = (m_tc + 1 > 255) ? 255 : m_tc + 1;
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

  // monitor: compares every cycle the scoreboard holds an expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("instr_valid", int'(instr_valid), int'(e.iv));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
        chk("cycle_count", int'(cycle_count), e.cc);
        chk("taken_count", int'(taken_count), e.tc);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    rst_n = 1'b0;
    idle(); idle();
    @(negedge clk); #1 rst_n = 1'b1;

    // straight-line run from 0x010
    step(1, 'h010, 0, 0, 0, 0);
    repeat (5) idle();
    // run to 0x020 and branch to 0x3F8
    guard = 0;
    while (m_pc != 'h020 && guard < 64) begin idle(); guard++; end
    chk("reach_0x020", m_pc, 'h020);
    step(0, 0, 0, 1, 'h3F8, 0);
    idle(); idle(); idle();
    // branch while stalled is ignored
    step(0, 0, 1, 1, 'h123, 0);
    step(0, 0, 0, 0, 0, 0);
    idle();
    // sequential wrap
    guard = 0;
    while (m_pc != 'h3FF && guard < 64) begin idle(); guard++; end
    chk("reach_0x3FF", m_pc, 'h3FF);
    idle(); idle();
    // halt and branch together
    step(0, 0, 0, 1, 'h055, 1);
    idle(); idle();
    // restart from DONE
    step(1, 'h100, 0, 0, 0, 0);
    idle(); idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 1023)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 1023)), ($urandom_range(0, 40) == 0));
    end

    // taken_count saturation
    idle();
    step(1, 'h200, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 1, int'($urandom_range(0, 1023)), 0);
      idle();
    end
    idle();
    chk("taken_sat_model", m_tc, 255);

    // async reset in the middle of a flush bubble
    step(0, 0, 0, 1, 'h077, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc), 0);
    chk("async_rst_iv", int'(instr_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_cc", int'(cycle_count), 0);
    chk("async_rst_tc", int'(taken_count), 0);
    model_reset();
    idle();
    @(negedge clk); #1 rst_n = 1'b1;
    step(1, 'h3FE, 0, 0, 0, 0);
    idle(); idle(); idle();

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    #5;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
